// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core load/store
// path (master 0) and a debug/host loader (master 1).
// Grants are combinational, one per cycle; responses return one cycle after
// acceptance to the master that issued the request.
// Optional feature macro: ARB_LOCK_EN enables the master-1 burst lock mode
// with a bounded LOCK_MAX starvation release for master 0.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic                m1_lock_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    if (LOCK_MAX < 2 || LOCK_MAX > 255) begin : g_bad_lock_max
        $error("dmem_arbiter: LOCK_MAX must be in 2..255");
    end

    // Requests are masked while reset is held so no grant leaks out.
    logic req0, req1;
    logic gnt0, gnt1;

    // Round-robin pointer: 0 favours master 0 on contention.
    logic prio_q, prio_d;

    // Response pipeline: pending flag, owner (1 = master 1), access was a write.
    logic pend_q, pend_d;
    logic own_q,  own_d;
    logic we_q,   we_d;

    assign req0 = m0_req_i & ~rst_i;
    assign req1 = m1_req_i & ~rst_i;

`ifdef ARB_LOCK_EN
    typedef enum logic {ST_ARB, ST_LOCK} state_e;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    state_e     state_q, state_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       base_prio;

    // Grant selection, lock-state transitions and lock counting.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        prio_d     = prio_q;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        base_prio  = prio_q;
        if (state_q == ST_LOCK && m1_lock_i) begin
            // Master 1 owns the port; master 0 gets a slot only when the
            // count has reached LOCK_MAX or master 1 is idle.
            if (req0 && (lock_cnt_q == LOCK_MAX_C || !req1)) begin
                gnt0 = 1'b1;
                if (lock_cnt_q == LOCK_MAX_C) begin
                    lock_cnt_d = 8'd0;
                end
            end else if (req1) begin
                gnt1 = 1'b1;
                if (lock_cnt_q != LOCK_MAX_C) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
        end else begin
            // Leaving LOCK restarts round-robin from master 0 in this same cycle.
            if (state_q == ST_LOCK) begin
                base_prio  = 1'b0;
                state_d    = ST_ARB;
                lock_cnt_d = 8'd0;
            end
            if (req0 && (!req1 || !base_prio)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
            prio_d = base_prio;
            if (gnt0) begin
                prio_d = 1'b1;
            end else if (gnt1) begin
                prio_d = 1'b0;
                if (m1_lock_i) begin
                    // The entering grant is the first counted master-1 grant.
                    state_d    = ST_LOCK;
                    lock_cnt_d = 8'd1;
                end
            end
        end
    end
`else
    logic unused_lock_in;
    assign unused_lock_in = m1_lock_i;

    // Pure round-robin grant selection.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        prio_d = prio_q;
        if (req0 && (!req1 || !prio_q)) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
    end
`endif

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // Shared memory port: mux of the granted master, all zero when idle.
    always_comb begin
        mem_req_o   = gnt0 | gnt1;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (gnt0) begin
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
            mem_be_o    = m0_be_i;
        end else if (gnt1) begin
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
            mem_be_o    = m1_be_i;
        end
    end

    // Capture owner and access type of the accepted request for the response.
    always_comb begin
        pend_d = gnt0 | gnt1;
        own_d  = gnt1;
        we_d   = mem_we_o;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q     <= 1'b0;
            pend_q     <= 1'b0;
            own_q      <= 1'b0;
            we_q       <= 1'b0;
`ifdef ARB_LOCK_EN
            state_q    <= ST_ARB;
            lock_cnt_q <= 8'd0;
`endif
        end else begin
            prio_q     <= prio_d;
            pend_q     <= pend_d;
            own_q      <= own_d;
            we_q       <= we_d;
`ifdef ARB_LOCK_EN
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    // Response routing; a pending response is dropped while reset is high.
    logic              rsp_v;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        rsp_v       = pend_q & ~rst_i;
        rsp_data    = (rsp_v && !we_q) ? mem_rdata_i : '0;
        m0_rvalid_o = rsp_v & ~own_q;
        m1_rvalid_o = rsp_v & own_q;
        m0_rdata_o  = own_q ? '0 : rsp_data;
        m1_rdata_o  = own_q ? rsp_data : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: scoreboard of expected responses, one task per scenario.
module tb_dmem_arbiter;

    localparam logic [31:0] RD_KEY  = 32'hA5A5_0000;
    localparam logic [31:0] JUNK    = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
    logic [3:0]  m0_be_i = '0;
    logic        m1_req_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
    logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
    logic [3:0]  m1_be_i = '0;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i = '0;

    typedef struct {
        logic        who;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i), .m1_lock_i(m1_lock_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    // Memory model: read data is a fixed function of the address, one cycle later.
    always @(posedge clk) begin
        mem_rdata_i <= (mem_req_o && !mem_we_o) ? (mem_addr_o ^ RD_KEY) : JUNK;
    end

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                         input logic r1, input logic [31:0] a1, input logic lk);
        m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0;
        m0_wdata_i = w0 ? 32'hDEAD_BEEF : 32'h0; m0_be_i = 4'hF;
        m1_req_i = r1; m1_we_i = 1'b0; m1_addr_i = a1;
        m1_wdata_i = 32'h0; m1_be_i = 4'hF; m1_lock_i = lk;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0);
        sb.delete();
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_req_o, mem_we_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_req_o, mem_we_o});
        end
        n_cmp++;
        if ({m0_rdata_o, m1_rdata_o, mem_addr_o, mem_wdata_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h want all 0",
                     m0_rdata_o, m1_rdata_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_rr_reads;
        rsp_t        r;
        logic [65:0] exp_rsp;
        logic        who;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b0);
            else       drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            exp_rsp = '0;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                exp_rsp = {~r.who, r.who, r.who ? 32'h0 : r.data, r.who ? r.data : 32'h0};
            end
            n_cmp++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== exp_rsp) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: got %h want %h", i,
                         {m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o}, exp_rsp);
            end
            if (i < 6) begin
                who = (i % 2 == 1);
                n_cmp++;
                if ({m0_gnt_o, m1_gnt_o, mem_req_o, mem_addr_o} !==
                    {~who, who, 1'b1, who ? 32'h200 : 32'h100}) begin
                    n_fail++;
                    $display("FAIL rr_gnt[%0d]: got %b%b addr %h want m%0d", i,
                             m0_gnt_o, m1_gnt_o, mem_addr_o, who);
                end
                sb.push_back('{who, (who ? 32'h200 : 32'h100) ^ RD_KEY});
            end
            tick();
        end
    endtask

    task automatic test_write_burst;
        rsp_t        r;
        logic [65:0] exp_rsp;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
            else       drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            exp_rsp = '0;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                exp_rsp = {~r.who, r.who, r.who ? 32'h0 : r.data, r.who ? r.data : 32'h0};
            end
            n_cmp++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== exp_rsp) begin
                n_fail++;
                $display("FAIL wr_rsp[%0d]: got %h want %h", i,
                         {m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o}, exp_rsp);
            end
            if (i < 3) begin
                n_cmp++;
                if ({m0_gnt_o, m1_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !==
                    {4'b1011, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
                    n_fail++;
                    $display("FAIL wr_port[%0d]: got %b%b%b%b %h %h %h", i, m0_gnt_o, m1_gnt_o,
                             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
                end
                sb.push_back('{1'b0, 32'h0});
            end
            tick();
        end
    endtask

    task automatic test_lock;
        rsp_t        r;
        logic [65:0] exp_rsp;
        logic [14:0] seq;
        logic        who;
`ifdef ARB_LOCK_EN
        seq = 15'h2BDE;
`else
        seq = 15'h2AAA;
`endif
        for (int i = 0; i < 16; i++) begin
            if (i < 15) drive(1'b1, 1'b0, 32'h300, 1'b1, 32'h400, i < 12);
            else        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            exp_rsp = '0;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                exp_rsp = {~r.who, r.who, r.who ? 32'h0 : r.data, r.who ? r.data : 32'h0};
            end
            n_cmp++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== exp_rsp) begin
                n_fail++;
                $display("FAIL lock_rsp[%0d]: got %h want %h", i,
                         {m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o}, exp_rsp);
            end
            if (i < 15) begin
                who = seq[i];
                n_cmp++;
                if ({m0_gnt_o, m1_gnt_o} !== {~who, who}) begin
                    n_fail++;
                    $display("FAIL lock_gnt[%0d]: got %b%b want m%0d", i, m0_gnt_o, m1_gnt_o, who);
                end
                sb.push_back('{who, (who ? 32'h400 : 32'h300) ^ RD_KEY});
            end
            tick();
        end
    endtask

    task automatic test_lock_saturate;
        rsp_t        r;
        logic [65:0] exp_rsp;
        logic        who;
        for (int i = 0; i < 9; i++) begin
            if (i < 6)      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b1);
            else if (i < 8) drive(1'b1, 1'b0, 32'h700, 1'b1, 32'h600, 1'b1);
            else            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            exp_rsp = '0;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                exp_rsp = {~r.who, r.who, r.who ? 32'h0 : r.data, r.who ? r.data : 32'h0};
            end
            n_cmp++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== exp_rsp) begin
                n_fail++;
                $display("FAIL sat_rsp[%0d]: got %h want %h", i,
                         {m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o}, exp_rsp);
            end
            if (i < 8) begin
                who = (i != 6);
                n_cmp++;
                if ({m0_gnt_o, m1_gnt_o} !== {~who, who}) begin
                    n_fail++;
                    $display("FAIL sat_gnt[%0d]: got %b%b want m%0d", i, m0_gnt_o, m1_gnt_o, who);
                end
                sb.push_back('{who, (who ? 32'h600 : 32'h700) ^ RD_KEY});
            end
            tick();
        end
    endtask

    task automatic test_reset_pending;
        drive(1'b1, 1'b0, 32'h500, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL rp_gnt: got %b%b want 10", m0_gnt_o, m1_gnt_o);
        end
        tick();
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m1_gnt_o, mem_req_o, m0_rdata_o, m1_rdata_o} !== 37'h0) begin
            n_fail++;
            $display("FAIL rp_drop: got rv %b%b gnt %b%b req %b rd %h %h want all 0",
                     m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m1_gnt_o, mem_req_o, m0_rdata_o, m1_rdata_o);
        end
        tick();
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 32'h540, 1'b1, 32'h580, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m1_gnt_o} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rp_first: got rv %b%b gnt %b%b want rv 00 gnt 10",
                     m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m1_gnt_o);
        end
        sb.push_back('{1'b0, 32'h540 ^ RD_KEY});
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        if (sb.size() != 0) begin
            rsp_t r;
            r = sb.pop_front();
            n_cmp++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== {1'b1, 1'b0, r.data}) begin
                n_fail++;
                $display("FAIL rp_rsp: got %b%b %h want 10 %h", m0_rvalid_o, m1_rvalid_o,
                         m0_rdata_o, r.data);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_reads();
        test_reset();
        test_write_burst();
        test_reset();
        test_lock();
        test_reset();
        test_lock_saturate();
        test_reset();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
